// File: rtl/fb_pixel_fetch_pkg.sv
// Shared types and default timing for the framebuffer pixel prefetch stage.
package fb_pixel_fetch_pkg;

    localparam int PIX_W_DEF      = 4;
    localparam int DEPTH_DEF      = 4;
    localparam int STROBE_LEN_DEF = 2;
    localparam int SETTLE_DEF     = 3;

    typedef enum logic [2:0] {
        S_RESYNC  = 3'd0,
        S_STROBE  = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_WAIT    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fb_pixel_fetch_if.sv
// Consumer-side pixel stream: head pixel, pop, occupancy and underrun flag.
interface fb_pixel_fetch_if
    import fb_pixel_fetch_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int LVL_W = 3
);
    logic             pix_pop;
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic [LVL_W-1:0] level;
    logic             underrun;

    modport master (output pix_pop, input pix_data, pix_valid, level, underrun);
    modport slave  (input pix_pop, output pix_data, pix_valid, level, underrun);
endinterface

// File: rtl/fb_pixel_fetch_fifo.sv
// First-word-fall-through pixel FIFO: head entry is always visible on data_o.
module fb_pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int PIX_W = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [PIX_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [PIX_W-1:0] data_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [PIX_W-1:0] entry_w [DEPTH];
    logic             push_ok, pop_ok;

    assign valid_o = (level_q != '0);
    assign level_o = level_q;
    assign pop_ok  = pop_i && valid_o && !flush_i;
    assign push_ok = push_i && (level_q != LVL_W'(DEPTH)) && !flush_i;
    assign data_o  = entry_w[rd_ptr_q];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PIX_W-1:0] entry_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_q <= push_data_i;
                end
            end
            assign entry_w[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
            else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/fb_pixel_fetch.sv
// Drives the RP2040 framebuffer strobes, captures synchronized pixels and
// buffers them so the VGA scan-out can pop with zero wait.
module fb_pixel_fetch
    import fb_pixel_fetch_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int STROBE_LEN = STROBE_LEN_DEF,
    parameter int SETTLE     = SETTLE_DEF,
    parameter int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start_i,
    fb_pixel_fetch_if.slave  pix,
    output logic             fb_next_pixel_o,
    output logic             fb_reset_o,
    input  logic [PIX_W-1:0] fb_pixel_i
);
    localparam int CNT_MAX = (STROBE_LEN > SETTLE) ? STROBE_LEN : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] sync1_q, sync2_q;
    logic             underrun_q, underrun_d;
    logic             push;
    logic             fifo_valid;
    logic [LVL_W-1:0] fifo_level;
    logic [LVL_W-1:0] lvl_after_pop;

    fb_pixel_fifo #(.DEPTH(DEPTH), .PIX_W(PIX_W), .LVL_W(LVL_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (frame_start_i),
        .push_i     (push),
        .push_data_i(sync2_q),
        .pop_i      (pix.pix_pop),
        .data_o     (pix.pix_data),
        .valid_o    (fifo_valid),
        .level_o    (fifo_level)
    );

    assign pix.pix_valid = fifo_valid;
    assign pix.level     = fifo_level;
    assign pix.underrun  = underrun_q;

    // Reset holds the FSM in RESYNC, so the rewind pulse is masked until release.
    assign fb_reset_o      = (state_q == S_RESYNC) && !rst;
    assign fb_next_pixel_o = (state_q == S_STROBE);

    // Occupancy as it will stand after this cycle's pop, before any capture.
    assign lvl_after_pop = fifo_level - LVL_W'(pix.pix_pop && fifo_valid);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        underrun_d = underrun_q;
        if (pix.pix_pop && !fifo_valid) underrun_d = 1'b1;
        unique case (state_q)
            S_RESYNC, S_STROBE: begin
                if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                push    = 1'b1;
                state_d = (int'(lvl_after_pop) + 1 < DEPTH) ? S_STROBE : S_WAIT;
            end
            S_WAIT: begin
                if (int'(lvl_after_pop) < DEPTH) state_d = S_STROBE;
            end
            default: state_d = S_RESYNC;
        endcase
        if (frame_start_i) begin
            state_d    = S_RESYNC;
            cnt_d      = '0;
            push       = 1'b0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESYNC;
            cnt_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= fb_pixel_i;
            sync2_q    <= sync1_q;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Scoreboard bench: an RP2040 model queues each presented pixel, pops compare.
module tb_fb_pixel_fetch;
    localparam int DEPTH = 4;
    localparam int PIX_W = 4;
    localparam int LVL_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             fb_next_pixel;
    logic             fb_reset;
    logic [PIX_W-1:0] fb_pixel;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [PIX_W-1:0] exp_q [$];

    fb_pixel_fetch_if #(.PIX_W(PIX_W), .LVL_W(LVL_W)) pix_if ();

    fb_pixel_fetch #(.DEPTH(DEPTH), .PIX_W(PIX_W), .STROBE_LEN(2), .SETTLE(3), .LVL_W(LVL_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start_i  (frame_start),
        .pix            (pix_if.slave),
        .fb_next_pixel_o(fb_next_pixel),
        .fb_reset_o     (fb_reset),
        .fb_pixel_i     (fb_pixel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix_val(input int i);
        return PIX_W'((i + 1) & 15);
    endfunction

    function automatic logic [PIX_W-1:0] head_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q[0];
    endfunction

    // RP2040 model: rewinds on fb_reset, advances once per strobe pulse.
    initial begin
        int  idx;
        logic prev_rst, prev_next;
        idx = 0; prev_rst = 1'b0; prev_next = 1'b0; fb_pixel = '0;
        forever begin
            @(negedge clk);
            if (fb_reset) begin
                idx = 0;
                fb_pixel = pix_val(0);
                if (!prev_rst) exp_q.push_back(pix_val(0));
            end else if (fb_next_pixel && !prev_next) begin
                idx++;
                fb_pixel = pix_val(idx);
                exp_q.push_back(pix_val(idx));
            end
            prev_rst  = fb_reset;
            prev_next = fb_next_pixel;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one(input string tag);
        pix_if.pix_pop = 1'b1;
        check({tag, "_valid"}, 32'(pix_if.pix_valid), 32'd1);
        check(tag, 32'(pix_if.pix_data), 32'(head_exp()));
        $display("[TB] pop %s data=0x%0h level=%0d", tag, pix_if.pix_data, pix_if.level);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        step();
        pix_if.pix_pop = 1'b0;
    endtask

    task automatic wait_level(input logic [LVL_W-1:0] target, input string tag);
        int n = 0;
        while (pix_if.level != target && n < 60) begin step(); n++; end
        check(tag, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!pix_if.pix_valid && n < 60) begin step(); n++; end
        check(tag, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_next(input logic v, input string tag);
        int n = 0;
        while (fb_next_pixel != v && n < 60) begin step(); n++; end
        check(tag, 32'(n < 60), 32'd1);
    endtask

    initial begin
        int  rises, last_rise, cur_w, width_bad, space_bad;
        logic prev;
        rst = 1'b1; frame_start = 1'b0; pix_if.pix_pop = 1'b0;
        repeat (3) step();
        check("rst_fb_reset", 32'(fb_reset), 32'd0);
        check("rst_fb_next",  32'(fb_next_pixel), 32'd0);
        check("rst_valid",    32'(pix_if.pix_valid), 32'd0);
        check("rst_level",    32'(pix_if.level), 32'd0);
        check("rst_underrun", 32'(pix_if.underrun), 32'd0);
        check("rst_data",     32'(pix_if.pix_data), 32'd0);

        rst = 1'b0; #1;
        check("resync_c1", 32'(fb_reset), 32'd1);
        step(); check("resync_c2", 32'(fb_reset), 32'd1);
        step(); check("resync_c3", 32'(fb_reset), 32'd0);
        step(); step(); check("pre_cap_level", 32'(pix_if.level), 32'd0);
        step(); step(); check("first_cap_level", 32'(pix_if.level), 32'd1);
        $display("[TB] first capture data=0x%0h", pix_if.pix_data);

        // Fill: watch strobe pulses until the FIFO saturates.
        rises = 0; last_rise = 0; cur_w = 0; width_bad = 0; space_bad = 0; prev = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (fb_next_pixel && !prev) begin
                if (rises > 0 && (c - last_rise) != 6) space_bad = 1;
                rises++;
                last_rise = c;
            end
            if (fb_next_pixel) cur_w++;
            if (!fb_next_pixel && prev) begin
                if (cur_w != 2) width_bad = 1;
                cur_w = 0;
            end
            prev = fb_next_pixel;
            step();
        end
        check("fill_rises",     32'(rises), 32'd3);
        check("fill_width_bad", 32'(width_bad), 32'd0);
        check("fill_space_bad", 32'(space_bad), 32'd0);
        check("fill_level",     32'(pix_if.level), 32'd4);
        check("fill_strobe",    32'(fb_next_pixel), 32'd0);
        check("fill_head",      32'(pix_if.pix_data), 32'(head_exp()));

        // Drain at full; strobing must resume the cycle after the first pop.
        for (int i = 0; i < 4; i++) begin
            if (i == 0) check("drain_hold",   32'(fb_next_pixel), 32'd0);
            if (i == 1) check("drain_resume", 32'(fb_next_pixel), 32'd1);
            pop_one("drain");
        end
        check("drain_level", 32'(pix_if.level), 32'd0);

        // Underrun: pop on empty.
        pix_if.pix_pop = 1'b1;
        check("ur_pre", 32'(pix_if.underrun), 32'd0);
        step();
        pix_if.pix_pop = 1'b0;
        check("ur_set",   32'(pix_if.underrun), 32'd1);
        check("ur_level", 32'(pix_if.level), 32'd0);
        wait_valid("refill_wait");
        check("refill_data",  32'(pix_if.pix_data), 32'(head_exp()));
        check("ur_sticky",    32'(pix_if.underrun), 32'd1);

        // Frame start in the middle of a strobe at level 2.
        wait_level(3'd2, "fs_wait_level");
        wait_next(1'b1, "fs_wait_strobe");
        check("fs_pre_level", 32'(pix_if.level), 32'd2);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        exp_q.delete();
        check("fs_strobe",   32'(fb_next_pixel), 32'd0);
        check("fs_level",    32'(pix_if.level), 32'd0);
        check("fs_valid",    32'(pix_if.pix_valid), 32'd0);
        check("fs_underrun", 32'(pix_if.underrun), 32'd0);
        check("fs_reset_c1", 32'(fb_reset), 32'd1);
        step(); check("fs_reset_c2", 32'(fb_reset), 32'd1);
        step(); check("fs_reset_c3", 32'(fb_reset), 32'd0);
        wait_valid("fs_refill_wait");
        check("fs_first_pix", 32'(pix_if.pix_data), 32'(head_exp()));

        // Pop during the CAPTURE cycle at level 2.
        wait_level(3'd2, "sim_wait_level");
        wait_next(1'b1, "sim_wait_strobe");
        wait_next(1'b0, "sim_wait_settle");
        repeat (3) step();
        check("sim_pre_level", 32'(pix_if.level), 32'd2);
        pop_one("sim_pop");
        check("sim_level", 32'(pix_if.level), 32'd2);
        pop_one("sim_next");
        pop_one("sim_tail");
        check("sim_end_level", 32'(pix_if.level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
